karatsuba_mult_pipe: RTL and testbench

//   Parametrised, fully pipelined one-level Karatsuba multiplier: WIDTH x WIDTH -> 2*WIDTH unsigned.

---
 rtl/karatsuba_pkg.sv | 28 ++
 rtl/karatsuba_mult_pipe_chk.sv | 22 ++
 rtl/karatsuba_pipe_mul.sv | 37 +++
 rtl/karatsuba_mult_pipe.sv | 142 ++++++++++++++
 tb/tb_karatsuba_mult_pipe.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/karatsuba_pkg.sv
// Shared constants and sizing helpers for the Karatsuba multiplier and the
// modular-reduction block that consumes its products.
package karatsuba_pkg;

   localparam int DEF_WIDTH      = 32'sd256;
   localparam int DEF_MUL_STAGES = 32'sd3;
   localparam int DEF_TAG_W      = 32'sd8;

   // Product widths at the default operand size, shared with the reducer
   localparam int DEF_HALF   = DEF_WIDTH / 32'sd2;
   localparam int DEF_Z_W    = 32'sd2 * DEF_HALF;
   localparam int DEF_ZM_W   = 32'sd2 * DEF_HALF + 32'sd2;
   localparam int DEF_PROD_W = 32'sd2 * DEF_WIDTH;

   typedef enum logic [0:0] {
      OP_MUL    = 1'b0,
      OP_SQUARE = 1'b1
   } op_kind_e;

   function automatic int HALF(input int width);
      return width / 32'sd2;
   endfunction

   function automatic int LATENCY(input int mul_stages);
      return mul_stages + 32'sd2;
   endfunction

endpackage

// File: rtl/karatsuba_mult_pipe_chk.sv
// Protocol checker for karatsuba_mult_pipe: a stalled result must hold,
// and in_ready must follow the global advance condition.
module karatsuba_mult_pipe_chk #(
   parameter int WIDTH = 256,
   parameter int TAG_W = 8
) (
   input logic               clock,
   input logic               reset_n,
   input logic               in_ready,
   input logic               out_valid,
   input logic               out_ready,
   input logic [2*WIDTH-1:0] out_p,
   input logic [TAG_W-1:0]   out_tag
);

   a_hold_stalled: assert property (@(posedge clock) disable iff (!reset_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_p) && $stable(out_tag)));

   a_ready_is_adv: assert property (@(posedge clock) disable iff (!reset_n)
      in_ready == (out_ready || !out_valid));

endmodule

// File: rtl/karatsuba_pipe_mul.sv
// Pipelined unsigned multiplier: the product enters the first of STAGES
// registers and then shifts through the rest; the whole chain holds when en=0.
module karatsuba_pipe_mul #(
   parameter int A_W    = 128,
   parameter int B_W    = 128,
   parameter int STAGES = 3
) (
   input  logic               clock,
   input  logic               en,
   input  logic [A_W-1:0]     a,
   input  logic [B_W-1:0]     b,
   output logic [A_W+B_W-1:0] p
);

   localparam int P_W = A_W + B_W;

   logic [P_W-1:0] prod_s;
   logic [P_W-1:0] pipe_r [STAGES];

   // Full-width product of the zero-extended operands
   always_comb begin
      prod_s = {{B_W{1'b0}}, a} * {{A_W{1'b0}}, b};
   end

   // Product shift chain; datapath only, so no reset
   always_ff @(posedge clock) begin
      if (en) begin
         pipe_r[0] <= prod_s;
         for (int i = 32'sd1; i < STAGES; i++) begin
            pipe_r[i] <= pipe_r[i-1];
         end
      end
   end

   assign p = pipe_r[STAGES-1];

endmodule

// File: rtl/karatsuba_mult_pipe.sv
// One-level Karatsuba WIDTH x WIDTH multiplier with ready/valid flow control,
// a caller tag per operation and a square mode; one global advance enable.
module karatsuba_mult_pipe
   import karatsuba_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int MUL_STAGES = DEF_MUL_STAGES,
   parameter int TAG_W      = DEF_TAG_W
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_x,
   input  logic [WIDTH-1:0]   in_y,
   input  logic               in_square,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int H   = HALF(WIDTH);
   localparam int LAT = LATENCY(MUL_STAGES);
   localparam int PW  = 2 * WIDTH;
   localparam int ZW  = 2 * H;
   localparam int ZMW = 2 * H + 2;

   logic             adv_s;
   logic [WIDTH-1:0] y_sel_s;

   logic [H-1:0]     x0_r;
   logic [H-1:0]     x1_r;
   logic [H-1:0]     y0_r;
   logic [H-1:0]     y1_r;
   logic [H:0]       sx_r;
   logic [H:0]       sy_r;

   logic [ZW-1:0]    z0_s;
   logic [ZW-1:0]    z2_s;
   logic [ZMW-1:0]   zm_s;
   logic [ZMW-1:0]   z1_s;
   logic [PW-1:0]    p_s;

   logic [LAT-1:0]   vld_r;
   logic [TAG_W-1:0] tag_r [LAT-1];
   logic [PW-1:0]    out_p_r;
   logic [TAG_W-1:0] out_tag_r;

   // Everything moves together unless a held result is still waiting downstream
   assign adv_s    = out_ready | ~vld_r[LAT-1];
   assign in_ready = adv_s;

   // Operand Y selection for square mode
   always_comb begin
      if (op_kind_e'(in_square) == OP_SQUARE) begin
         y_sel_s = in_x;
      end else begin
         y_sel_s = in_y;
      end
   end

   // Stage 0: split halves and form the pre-add sums
   always_ff @(posedge clock) begin
      if (adv_s) begin
         x0_r <= in_x[H-1:0];
         x1_r <= in_x[WIDTH-1:H];
         y0_r <= y_sel_s[H-1:0];
         y1_r <= y_sel_s[WIDTH-1:H];
         sx_r <= {1'b0, in_x[H-1:0]} + {1'b0, in_x[WIDTH-1:H]};
         sy_r <= {1'b0, y_sel_s[H-1:0]} + {1'b0, y_sel_s[WIDTH-1:H]};
      end
   end

   karatsuba_pipe_mul #(.A_W(H), .B_W(H), .STAGES(MUL_STAGES)) u_mul_z0 (
      .clock (clock),
      .en    (adv_s),
      .a     (x0_r),
      .b     (y0_r),
      .p     (z0_s)
   );

   karatsuba_pipe_mul #(.A_W(H), .B_W(H), .STAGES(MUL_STAGES)) u_mul_z2 (
      .clock (clock),
      .en    (adv_s),
      .a     (x1_r),
      .b     (y1_r),
      .p     (z2_s)
   );

   karatsuba_pipe_mul #(.A_W(H + 1), .B_W(H + 1), .STAGES(MUL_STAGES)) u_mul_zm (
      .clock (clock),
      .en    (adv_s),
      .a     (sx_r),
      .b     (sy_r),
      .p     (zm_s)
   );

   // Combine: the middle term is exact in 2H+2 bits since ZM >= Z0 + Z2
   always_comb begin
      z1_s = zm_s - {2'b00, z0_s} - {2'b00, z2_s};
      p_s  = {z2_s, {WIDTH{1'b0}}}
           + {{(H - 2){1'b0}}, z1_s, {H{1'b0}}}
           + {{WIDTH{1'b0}}, z0_s};
   end

   // Valid chain; clearing it is what discards in-flight work on reset
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vld_r <= {LAT{1'b0}};
      end else if (adv_s) begin
         vld_r <= {vld_r[LAT-2:0], in_valid};
      end
   end

   // Tag chain up to the stage feeding the combine
   always_ff @(posedge clock) begin
      if (adv_s) begin
         tag_r[0] <= in_tag;
         for (int i = 32'sd1; i < LAT - 1; i++) begin
            tag_r[i] <= tag_r[i-1];
         end
      end
   end

   // Output stage register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_p_r   <= {PW{1'b0}};
         out_tag_r <= {TAG_W{1'b0}};
      end else if (adv_s) begin
         out_p_r   <= p_s;
         out_tag_r <= tag_r[LAT-2];
      end
   end

   assign out_valid = vld_r[LAT-1];
   assign out_p     = out_p_r;
   assign out_tag   = out_tag_r;

endmodule

// File: tb/tb_karatsuba_mult_pipe.sv
// Self-checking bench for karatsuba_mult_pipe: arithmetic reference model with an
// ordered scoreboard, plus directed vectors with hand-derived products.
`timescale 1ns/100ps
module tb_karatsuba_mult_pipe;

   localparam int W   = 256;
   localparam int MS  = 3;
   localparam int TW  = 8;
   localparam int LAT = 5;
   localparam int PW  = 512;

   logic          clock     = 1'b0;
   logic          reset_n   = 1'b0;
   logic          in_valid  = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_x      = '0;
   logic [W-1:0]  in_y      = '0;
   logic          in_square = 1'b0;
   logic [TW-1:0] in_tag    = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [PW-1:0] out_p;
   logic [TW-1:0] out_tag;

   always #5 clock = ~clock;

   karatsuba_mult_pipe #(.WIDTH(W), .MUL_STAGES(MS), .TAG_W(TW)) dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_square(in_square), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag)
   );

   karatsuba_mult_pipe_chk #(.WIDTH(W), .TAG_W(TW)) chk (
      .clock(clock), .reset_n(reset_n), .in_ready(in_ready), .out_valid(out_valid),
      .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag)
   );

   typedef struct {
      logic [PW-1:0] p;
      logic [TW-1:0] tag;
      int            cyc;
   } exp_t;

   exp_t q[$];
   int   n_cmp   = 0;
   int   n_bad   = 0;
   int   cyc     = 0;
   int   n_in    = 0;
   int   n_out   = 0;
   int   run     = 0;
   int   max_run = 0;
   bit   lat_chk = 1'b0;
   bit   done_r  = 1'b0;

   task automatic check(input bit ok, input string name, input logic [PW-1:0] act,
                        input logic [PW-1:0] req);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [PW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [PW-1:0] a;
      logic [PW-1:0] b;
      a = PW'(x);
      b = PW'(y);
      return a * b;
   endfunction

   function automatic logic [W-1:0] rand256();
      logic [W-1:0] r;
      for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   initial forever begin
      @(negedge reset_n);
      q.delete();
   end

   // Scoreboard: record accepted ops, check every delivered result in order
   initial forever begin
      exp_t e;
      @(negedge clock);
      if (reset_n) begin
         if (out_valid) run++;
         else run = 0;
         if (run > max_run) max_run = run;
         if (in_valid && in_ready) begin
            e.p   = model(in_x, in_square ? in_x : in_y);
            e.tag = in_tag;
            e.cyc = cyc;
            q.push_back(e);
            n_in++;
         end
         if (out_valid && out_ready) begin
            check(q.size() != 0, "out_has_pending", PW'(q.size()), PW'(1));
            if (q.size() != 0) begin
               e = q.pop_front();
               n_out++;
               check(out_p == e.p, "model_p", out_p, e.p);
               check(out_tag == e.tag, "model_tag", PW'(out_tag), PW'(e.tag));
               if (lat_chk) check(cyc - e.cyc == LAT, "latency", PW'(cyc - e.cyc), PW'(LAT));
            end
         end
      end
   end

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic sq,
                       input logic [TW-1:0] t);
      int k = 0;
      in_valid = 1'b1; in_x = x; in_y = y; in_square = sq; in_tag = t;
      @(negedge clock);
      while (!in_ready && k < 200) begin
         @(negedge clock);
         k++;
      end
      if (k >= 200) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: actual=%0d cycles required=<200", k);
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_result(input logic [PW-1:0] ep, input logic [TW-1:0] et,
                              input string name);
      int k = 0;
      do begin
         @(negedge clock);
         k++;
      end while (!(out_valid && out_ready) && k < 50);
      check(k < 50, {name, "_arrive"}, PW'(k), PW'(LAT + 1));
      check(out_p == ep, {name, "_p"}, out_p, ep);
      check(out_tag == et, {name, "_tag"}, PW'(out_tag), PW'(et));
      @(posedge clock); #1;
   endtask

   task automatic drain();
      int k = 0;
      while (q.size() != 0 && k < 3000) begin
         @(negedge clock);
         k++;
      end
      check(q.size() == 0, "drain_empty", PW'(q.size()), PW'(0));
      @(posedge clock); #1;
   endtask

   initial begin
      logic [PW-1:0] e_p;
      logic [PW-1:0] fp;
      logic [TW-1:0] ft;
      logic [W-1:0]  xv;

      #12;
      check(out_valid == 1'b0, "reset_out_valid", PW'(out_valid), PW'(0));
      check(out_p == '0, "reset_out_p", out_p, PW'(0));
      check(out_tag == '0, "reset_out_tag", PW'(out_tag), PW'(0));
      check(in_ready == 1'b1, "reset_in_ready", PW'(in_ready), PW'(1));
      #11 reset_n = 1'b1;
      @(posedge clock); #1;
      lat_chk = 1'b1;

      // 1: all-ones operands
      e_p = {{63{4'hF}}, 4'hE, {63{4'h0}}, 4'h1};
      send({W{1'b1}}, {W{1'b1}}, 1'b0, 8'h5A);
      wait_result(e_p, 8'h5A, "t1_ones");

      // 2: back-to-back random stream
      max_run = 0;
      for (int i = 0; i < 11; i++) send(rand256(), rand256(), 1'b0, 8'(i));
      drain();
      @(negedge clock);
      check(max_run == 11, "t2_consecutive", PW'(max_run), PW'(11));
      @(posedge clock); #1;

      // 3: fill with the output stalled, hold for 6 cycles, then release
      lat_chk = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(rand256(), rand256(), 1'b0, 8'(8'h20 + i));
      xv = rand256();
      in_valid = 1'b1; in_x = xv; in_y = xv; in_square = 1'b1; in_tag = 8'h25;
      @(negedge clock);
      fp = out_p; ft = out_tag;
      check(out_valid == 1'b1, "t3_full_valid", PW'(out_valid), PW'(1));
      check(ft == 8'h20, "t3_head_tag", PW'(ft), PW'(8'h20));
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         check(in_ready == 1'b0, "t3_in_ready_low", PW'(in_ready), PW'(0));
         check(out_p == fp, "t3_p_frozen", out_p, fp);
         check(out_tag == ft, "t3_tag_frozen", PW'(out_tag), PW'(ft));
      end
      @(posedge clock); #1;
      out_ready = 1'b1;
      send(xv, xv, 1'b1, 8'h25);
      drain();

      done_r = 1'b0;
      fork
         begin
            for (int i = 0; i < 200; i++)
               send(rand256(), rand256(), 1'($urandom_range(0, 1)), 8'(i));
            done_r = 1'b1;
         end
         begin
            while (!done_r) begin
               @(posedge clock); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      drain();
      check(n_in == n_out, "t3_no_loss_dup", PW'(n_out), PW'(n_in));
      lat_chk = 1'b1;

      // 4: square mode ignores Y
      send(W'(3), W'(16'hDEAD), 1'b1, 8'h41);
      wait_result(PW'(9), 8'h41, "t4_sq3");
      e_p = {2'b01, 510'b0};
      send({1'b1, 255'b0}, rand256(), 1'b1, 8'h42);
      wait_result(e_p, 8'h42, "t4_sq2p255");

      // 5: both pre-adds carry out of H bits
      xv = {1'b1, 127'b0, 1'b1, 127'b0};
      e_p = '0; e_p[510] = 1'b1; e_p[383] = 1'b1; e_p[254] = 1'b1;
      send(xv, xv, 1'b0, 8'h55);
      wait_result(e_p, 8'h55, "t5_carry");

      // 6: asynchronous reset pulse with three ops in flight
      for (int i = 0; i < 3; i++) send(rand256(), rand256(), 1'b0, 8'(8'h60 + i));
      #2 reset_n = 1'b0;
      #0.5;
      check(out_valid == 1'b0, "t6_rst_valid", PW'(out_valid), PW'(0));
      check(out_p == '0, "t6_rst_p", out_p, PW'(0));
      check(out_tag == '0, "t6_rst_tag", PW'(out_tag), PW'(0));
      #0.5 reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         check(out_valid == 1'b0, "t6_no_stale", PW'(out_valid), PW'(0));
      end
      @(posedge clock); #1;
      send(W'(5), W'(7), 1'b0, 8'h77);
      wait_result(PW'(35), 8'h77, "t6_after_rst");
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
